prefetch_bus_unit: RTL and testbench
====================================

Name: prefetch_bus_unit

Overview:
- Parametrised bus interface unit for the next-generation hmc-6502 core.
- Sits between the control/datapath and memory. Keeps a DEPTH-entry instruction prefetch queue, and arbitrates a single-outstanding memory bus between opcode prefetch and datapath load/store accesses.
- Adds behaviour the current core lacks: memory wait states via mem_ready, prefetch buffering, and branch flush with redirect.

Parameters:
- AW, 16, address width; fetch PC wraps modulo 2^AW.
- DW, 8, data width of the bus and of queue entries.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 16'hFFFC, fetch address loaded at reset, truncated to AW.

Ports:
- ph1  in  1  single clock; all state updates on rising edge.
- resetb  in  1  asynchronous active-low reset.
- mem_addr  out  AW  bus address; registered.
- mem_read_en  out  1  read strobe; registered.
- mem_write_en  out  1  write strobe; registered.
- mem_wdata  out  DW  write data; registered.
- mem_rdata  in  DW  read data; sampled on edge where mem_ready=1.
- mem_ready  in  1  memory completes current access this cycle.
- q_valid  out  1  queue non-empty.
- q_data  out  DW  head byte.
- q_pc  out  AW  address of head byte.
- q_pop  in  1  consume head byte.
- flush  in  1  discard queue; redirect fetch.
- flush_addr  in  AW  new fetch address.
- dreq  in  1  datapath access request; level, held until dack.
- dwe  in  1  1 = store, 0 = load; stable while dreq.
- daddr  in  AW  data address; stable while dreq.
- dwdata  in  DW  store data; stable while dreq.
- dack  out  1  one-cycle completion pulse.
- drdata  out  DW  load data; valid when dack=1 (load), holds until next load completes.

Behaviour:
- Reset (asynchronous, resetb=0):
  - Outputs: mem_read_en=0, mem_write_en=0, mem_addr=0, mem_wdata=0, dack=0, drdata=0, q_valid=0, q_data=0, q_pc=0.
  - Internal: fetch_pc=RESET_PC, count=0, state=IDLE, discard=0.
  - Reset mid-access abandons the access without any completion.
- States: IDLE, FETCH, DATA. At most one bus access outstanding.
- From IDLE, evaluated each edge:
  - If dreq=1 and dack=0: go to DATA, drive daddr/dwdata, assert mem_read_en=!dwe and mem_write_en=dwe.
  - Else if count<DEPTH and flush=0: go to FETCH, mem_addr=fetch_pc, mem_read_en=1.
  - Else stay in IDLE.
  - Data access has priority and never preempts an in-flight fetch.
- FETCH or DATA: strobes and address are held until mem_ready is sampled 1 (unbounded wait states). On that edge:
  - FETCH completion:
    - If discard=0: push {mem_rdata, fetch_pc} and set fetch_pc=fetch_pc+1 (wrapping).
    - If discard=1: drop the data and clear discard.
  - DATA completion: dack=1 for the next cycle; drdata=mem_rdata if load.
  - Next state is chosen with the IDLE rules in the same edge. Back-to-back accesses are allowed with no idle cycle; strobes deassert only if nothing is issued.
- Queue:
  - Circular buffer with count of width clog2(DEPTH)+1.
  - q_data and q_pc are combinational from the head entry. q_valid = count!=0.
  - q_pop with count=0 is ignored.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Issue rule count<DEPTH guarantees no overflow, because only one fetch is in flight and pop only decreases count.
- flush=1 (one-cycle pulse):
  - count=0, head/tail reset, fetch_pc=flush_addr. Takes priority over a same-cycle pop or push.
  - If a FETCH is in flight: set discard=1; the bus cycle still completes and its data is dropped.
  - An in-flight or pending DATA access is unaffected.
  - Fetch from flush_addr starts no earlier than the cycle after flush.
  - A second flush while discard=1 keeps discard=1 and updates fetch_pc to the new address.
- dack: while dack=1, state does not start a new DATA access. This prevents double service of a dreq that is still high in the same cycle.
- Throughput: with mem_ready tied 1, one byte per cycle enters the queue. First byte after reset is visible as q_valid=1 on the 2nd cycle after resetb rises.

Test Plan:
- Reset, mem_ready=1, memory returns low address byte: q_pc sequence FFFC, FFFD, FFFE, FFFF, then 0000 (wrap). Queue stops at 4 entries with q_pop=0; mem_read_en drops.
- mem_ready low 3 cycles per access: mem_addr and mem_read_en stable across waits. Exactly one push per access; q_data matches memory contents.
- dreq store daddr=0x0200, dwdata=0xA5 while a fetch is in flight: fetch completes first, then mem_write_en=1 with addr 0x0200 and data 0xA5. dack is a single pulse and there is no second write.
- Load from 0x0010 holding 0x3C: drdata=0x3C with dack=1. Prefetch resumes on the following access.
- flush to 0x1234 during a fetch waiting on mem_ready: the old byte is discarded, q_valid=0, and the next pushed entry has q_pc=0x1234.
- Full queue with simultaneous q_pop and completing fetch: count stays 4. Pop on empty: no change, no underflow.

Source files
------------

// File: rtl/prefetch_bus_unit.sv
// Bus interface unit: DEPTH-entry opcode prefetch queue plus a single
// outstanding memory access shared between prefetch and datapath load/store.
// Memory wait states are inserted by holding mem_ready low; flush empties the
// queue and redirects fetch, dropping the data of a fetch already on the bus.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no bus access outstanding, strobes low
// FETCH | opcode prefetch from fetch_pc in progress
// DATA  | datapath load or store in progress
module prefetch_bus_unit #(
    parameter int          AW       = 16,
    parameter int          DW       = 8,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_FFFC
) (
    input  logic          ph1,
    input  logic          resetb,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read_en,
    output logic          mem_write_en,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          q_valid,
    output logic [DW-1:0] q_data,
    output logic [AW-1:0] q_pc,
    input  logic          q_pop,
    input  logic          flush,
    input  logic [AW-1:0] flush_addr,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic          dack,
    output logic [DW-1:0] drdata
);

    localparam int              PW             = $clog2(DEPTH);
    localparam int              CW             = PW + 1;
    localparam logic [AW-1:0]   RESET_FETCH_PC = RESET_PC[AW-1:0];
    localparam logic [CW-1:0]   DEPTH_C        = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   fetch_pc, fetch_pc_n;
    logic [CW-1:0]   count, count_n;
    logic [PW-1:0]   head, head_n;
    logic [PW-1:0]   tail, tail_n;
    logic            discard, discard_n;

    logic [AW-1:0]   addr_n;
    logic            re_n;
    logic            we_n;
    logic [DW-1:0]   wdata_n;
    logic            dack_n;
    logic [DW-1:0]   drdata_n;

    logic [DW-1:0]   q_data_mem [DEPTH];
    logic [AW-1:0]   q_pc_mem   [DEPTH];

    logic            fetch_done;
    logic            data_done;
    logic            bus_wait;
    logic            push;
    logic            pop;

    assign fetch_done = (state == FETCH) && mem_ready;
    assign data_done  = (state == DATA)  && mem_ready;
    assign bus_wait   = (state != IDLE)  && !mem_ready;

    // A flush wins over both queue operations in the same cycle.
    assign push = fetch_done && !discard && !flush;
    assign pop  = q_pop && (count != '0) && !flush;

    assign q_valid = (count != '0);
    assign q_data  = q_valid ? q_data_mem[head] : '0;
    assign q_pc    = q_valid ? q_pc_mem[head]   : '0;

    // Queue pointers, occupancy, fetch address and the drop-next-fetch flag.
    always_comb begin
        count_n    = count;
        head_n     = head;
        tail_n     = tail;
        fetch_pc_n = fetch_pc;
        discard_n  = discard;

        if (flush) begin
            count_n    = '0;
            head_n     = '0;
            tail_n     = '0;
            fetch_pc_n = flush_addr;
            // Only a fetch still waiting on the bus needs its data dropped later;
            // one completing on this very edge is simply not pushed.
            discard_n  = (state == FETCH) && !mem_ready;
        end else begin
            if (fetch_done) begin
                discard_n = 1'b0;
            end
            if (push) begin
                tail_n     = tail + PW'(1);
                fetch_pc_n = fetch_pc + AW'(1);
            end
            if (pop) begin
                head_n = head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_n = count + CW'(1);
                2'b01:   count_n = count - CW'(1);
                default: count_n = count;
            endcase
        end
    end

    // Bus sequencing: hold during wait states, otherwise pick the next access.
    // The issue test uses the post-edge occupancy so a fetch launched on the
    // same edge as a push can never overflow the queue.
    always_comb begin
        state_n  = state;
        addr_n   = mem_addr;
        re_n     = mem_read_en;
        we_n     = mem_write_en;
        wdata_n  = mem_wdata;
        dack_n   = data_done;
        drdata_n = drdata;

        if (data_done && mem_read_en) begin
            drdata_n = mem_rdata;
        end

        if (!bus_wait) begin
            // data_done blocks a restart on the completion edge, dack on the next.
            if (dreq && !dack && !data_done) begin
                state_n = DATA;
                addr_n  = daddr;
                re_n    = !dwe;
                we_n    = dwe;
                wdata_n = dwdata;
            end else if ((count_n < DEPTH_C) && !flush) begin
                state_n = FETCH;
                addr_n  = fetch_pc_n;
                re_n    = 1'b1;
                we_n    = 1'b0;
            end else begin
                state_n = IDLE;
                re_n    = 1'b0;
                we_n    = 1'b0;
            end
        end
    end

    // Control and bus output registers.
    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            state        <= IDLE;
            fetch_pc     <= RESET_FETCH_PC;
            count        <= '0;
            head         <= '0;
            tail         <= '0;
            discard      <= 1'b0;
            mem_addr     <= '0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            mem_wdata    <= '0;
            dack         <= 1'b0;
            drdata       <= '0;
        end else begin
            state        <= state_n;
            fetch_pc     <= fetch_pc_n;
            count        <= count_n;
            head         <= head_n;
            tail         <= tail_n;
            discard      <= discard_n;
            mem_addr     <= addr_n;
            mem_read_en  <= re_n;
            mem_write_en <= we_n;
            mem_wdata    <= wdata_n;
            dack         <= dack_n;
            drdata       <= drdata_n;
        end
    end

    // Queue storage; contents are only observable through q_valid, so no reset.
    always_ff @(posedge ph1) begin
        if (push) begin
            q_data_mem[tail] <= mem_rdata;
            q_pc_mem[tail]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_prefetch_bus_unit.sv
// Bench for prefetch_bus_unit: directed reset/fill/wait/store/load/flush
// steps followed by a randomized run against a byte-stream reference model.
module tb_prefetch_bus_unit;

    logic        ph1 = 1'b0;
    logic        resetb = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready = 1'b0;
    logic        q_valid;
    logic [7:0]  q_data;
    logic [15:0] q_pc;
    logic        q_pop = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] flush_addr = '0;
    logic        dreq = 1'b0;
    logic        dwe = 1'b0;
    logic [15:0] daddr = '0;
    logic [7:0]  dwdata = '0;
    logic        dack;
    logic [7:0]  drdata;

    logic [7:0]  mem [65536];
    int          checks = 0;
    int          failures = 0;
    int          writes = 0;
    logic [15:0] last_waddr = '0;
    logic [7:0]  last_wdata = '0;

    prefetch_bus_unit dut (
        .ph1(ph1), .resetb(resetb),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .q_valid(q_valid), .q_data(q_data), .q_pc(q_pc), .q_pop(q_pop),
        .flush(flush), .flush_addr(flush_addr),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .dack(dack), .drdata(drdata)
    );

    always #5 ph1 = ~ph1;

    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: snapshot bus outputs and mem_ready for the coming edge, then
    // apply the memory write and check that a waited access held steady.
    task automatic tick();
        logic [15:0] s_addr;
        logic        s_re, s_we, s_rdy;
        logic [7:0]  s_wdata;
        s_addr  = mem_addr;
        s_re    = mem_read_en;
        s_we    = mem_write_en;
        s_wdata = mem_wdata;
        s_rdy   = mem_ready;
        @(posedge ph1);
        @(negedge ph1);
        if (s_we && s_rdy) begin
            mem[s_addr] = s_wdata;
            writes++;
            last_waddr = s_addr;
            last_wdata = s_wdata;
        end
        if ((s_re || s_we) && !s_rdy) begin
            chk("hold_addr", mem_addr, s_addr);
            chk("hold_re", mem_read_en, s_re);
            chk("hold_we", mem_write_en, s_we);
            if (s_we) chk("hold_wdata", mem_wdata, s_wdata);
        end
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] old_addr;
        logic [15:0] pc_i;
        logic        got;
        logic        req_active, req_we, prev_dack;
        logic [15:0] req_addr;
        logic [7:0]  req_data;
        int          req_w0, req_age, starve;

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
        mem[16'h0010] = 8'h3C;

        // Reset values
        repeat (2) @(negedge ph1);
        chk("rst_re", mem_read_en, 0);
        chk("rst_we", mem_write_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_dack", dack, 0);
        chk("rst_drdata", drdata, 0);
        chk("rst_qvalid", q_valid, 0);
        chk("rst_qdata", q_data, 0);
        chk("rst_qpc", q_pc, 0);

        // Release reset with zero-wait memory: first fetch, then first byte
        resetb = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("first_re", mem_read_en, 1);
        chk("first_addr", mem_addr, 16'hFFFC);
        chk("first_qvalid", q_valid, 0);
        tick();
        chk("c2_qvalid", q_valid, 1);
        chk("c2_qpc", q_pc, 16'hFFFC);
        chk("c2_qdata", q_data, 8'hFC);

        // Fill to DEPTH without pops; strobe must drop
        repeat (6) tick();
        chk("full_re", mem_read_en, 0);
        chk("full_qvalid", q_valid, 1);

        // Drain exactly four entries with the bus stalled
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_i = 16'hFFFC + 16'(i);
            chk("drain_qpc", q_pc, pc_i);
            chk("drain_qdata", q_data, mem[pc_i]);
            q_pop = 1'b1;
            tick();
        end
        q_pop = 1'b0;
        chk("drained_empty", q_valid, 0);
        q_pop = 1'b1;
        tick();
        q_pop = 1'b0;
        chk("pop_empty", q_valid, 0);

        // Wait states on the wrapped fetch at 0000
        for (int i = 0; i < 3; i++) begin
            chk("wait_re", mem_read_en, 1);
            chk("wait_addr", mem_addr, 16'h0000);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("wrap_qvalid", q_valid, 1);
        chk("wrap_qpc", q_pc, 16'h0000);
        chk("wrap_qdata", q_data, 8'h00);
        chk("b2b_addr", mem_addr, 16'h0001);
        chk("b2b_re", mem_read_en, 1);

        // Store arriving while a fetch waits
        dreq = 1'b1; dwe = 1'b1; daddr = 16'h0200; dwdata = 8'hA5;
        writes = 0;
        repeat (2) tick();
        chk("st_fetch_first_re", mem_read_en, 1);
        chk("st_fetch_first_we", mem_write_en, 0);
        chk("st_fetch_first_addr", mem_addr, 16'h0001);
        mem_ready = 1'b1;
        tick();
        chk("st_we", mem_write_en, 1);
        chk("st_re", mem_read_en, 0);
        chk("st_addr", mem_addr, 16'h0200);
        chk("st_wdata", mem_wdata, 8'hA5);
        tick();
        chk("st_dack", dack, 1);
        chk("st_one_write", writes, 1);
        chk("st_mem", mem[16'h0200], 8'hA5);
        dreq = 1'b0;
        tick();
        chk("st_dack_pulse", dack, 0);
        chk("st_we_off", mem_write_en, 0);
        tick();
        chk("st_no_rewrite", writes, 1);

        // Load from 0x0010
        dreq = 1'b1; dwe = 1'b0; daddr = 16'h0010;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = dack;
        end
        chk("ld_dack", dack, 1);
        chk("ld_data", drdata, 8'h3C);
        dreq = 1'b0;
        tick();
        chk("ld_dack_pulse", dack, 0);
        chk("ld_hold", drdata, 8'h3C);
        chk("ld_no_write", writes, 1);

        // Flush while a fetch waits on mem_ready
        mem_ready = 1'b0;
        q_pop = 1'b1;
        tick();
        q_pop = 1'b0;
        chk("fl_pending", mem_read_en, 1);
        old_addr = mem_addr;
        flush = 1'b1; flush_addr = 16'h1234;
        tick();
        flush = 1'b0;
        chk("fl_empty", q_valid, 0);
        chk("fl_old_addr", mem_addr, old_addr);
        tick();
        chk("fl_still_empty", q_valid, 0);
        mem_ready = 1'b1;
        tick();
        chk("fl_dropped", q_valid, 0);
        chk("fl_new_addr", mem_addr, 16'h1234);
        tick();
        chk("fl_qvalid", q_valid, 1);
        chk("fl_qpc", q_pc, 16'h1234);
        chk("fl_qdata", q_data, 8'h34);

        // Randomized run against the byte-stream model
        flush = 1'b1; flush_addr = 16'h1000; exp_pc = 16'h1000;
        tick();
        flush = 1'b0;
        req_active = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
        req_w0 = 0; req_age = 0; starve = 0; prev_dack = dack;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (dack) begin
                chk("dack_single", prev_dack, 0);
                if (req_active) begin
                    if (req_we) begin
                        chk("rnd_st_count", writes - req_w0, 1);
                        chk("rnd_st_addr", last_waddr, req_addr);
                        chk("rnd_st_data", last_wdata, req_data);
                    end else begin
                        chk("rnd_ld_data", drdata, mem[req_addr]);
                        chk("rnd_ld_nowrite", writes - req_w0, 0);
                    end
                    req_active = 1'b0;
                    dreq = 1'b0;
                end else begin
                    chk("spurious_dack", dack, 0);
                end
            end
            prev_dack = dack;
            if (req_active) begin
                req_age++;
                if (req_age > 200) begin
                    chk("dack_timeout", dack, 1);
                    req_active = 1'b0;
                    dreq = 1'b0;
                end
            end
            if (q_valid) begin
                chk("rnd_qpc", q_pc, exp_pc);
                chk("rnd_qdata", q_data, mem[exp_pc]);
                starve = 0;
            end else begin
                starve++;
                if (starve > 300) begin
                    chk("starve", q_valid, 1);
                    starve = 0;
                end
            end

            mem_ready = ($urandom_range(0, 3) != 0);
            q_pop = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 39) == 0);
            if (flush) flush_addr = 16'($urandom_range(0, 16'h3FFF));
            if (flush) exp_pc = flush_addr;
            else if (q_pop && q_valid) exp_pc = exp_pc + 16'd1;

            if (!req_active && !dack && $urandom_range(0, 15) == 0) begin
                req_we   = 1'($urandom_range(0, 1));
                req_addr = 16'h8000 | 16'($urandom_range(0, 255));
                req_data = 8'($urandom_range(0, 255));
                dwe = req_we; daddr = req_addr; dwdata = req_data;
                dreq = 1'b1;
                req_active = 1'b1;
                req_w0 = writes;
                req_age = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
